// File: rtl/vector_dot_product_engine.sv
// Streams two operand vectors out of a dual-port RAM (1-cycle read latency)
// and accumulates the unsigned element products into one dot-product result.
module vector_dot_product_engine #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 12,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_a_addr,
   input  logic [ADDR_WIDTH-1:0] i_base_b_addr,
   input  logic [LEN_WIDTH-1:0]  i_length,
   output logic [ADDR_WIDTH-1:0] o_ram_a_addr,
   input  logic [DATA_WIDTH-1:0] i_ram_a_data,
   output logic [ADDR_WIDTH-1:0] o_ram_b_addr,
   input  logic [DATA_WIDTH-1:0] i_ram_b_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ACC_WIDTH-1:0]  o_result
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]              r_state;
   logic [ADDR_WIDTH-1:0]   r_ram_a_addr;
   logic [ADDR_WIDTH-1:0]   r_ram_b_addr;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [LEN_WIDTH-1:0]    r_cnt;
   logic [ACC_WIDTH-1:0]    r_acc;
   logic [ACC_WIDTH-1:0]    r_result;
   logic [1:0]              r_vld_pipe;
   logic                    r_busy;
   logic                    r_done;

   logic [2*DATA_WIDTH-1:0] w_prod;
   logic [ACC_WIDTH-1:0]    w_acc_sum;
   logic [LEN_WIDTH-1:0]    w_cnt_next;
   logic                    w_last_pair;

   assign w_prod      = i_ram_a_data * i_ram_b_data;
   assign w_acc_sum   = r_acc + ACC_WIDTH'(w_prod);
   assign w_cnt_next  = r_cnt + 1'b1;
   // vld_pipe[1] tags the pair on the data inputs now; [0] tags one still in the RAM
   assign w_last_pair = r_vld_pipe[1] & ~r_vld_pipe[0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ram_a_addr <= '0;
         r_ram_b_addr <= '0;
         r_len        <= '0;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_result     <= '0;
         r_vld_pipe   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_vld_pipe <= {r_vld_pipe[0], 1'b0};
         if (r_vld_pipe[1]) r_acc <= w_acc_sum;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_length != '0) begin
                     r_ram_a_addr <= i_base_a_addr;
                     r_ram_b_addr <= i_base_b_addr;
                     r_len        <= i_length;
                     r_cnt        <= LEN_WIDTH'(1);
                     r_vld_pipe   <= 2'b01;
                     r_acc        <= '0;
                     r_busy       <= 1'b1;
                     r_state      <= (i_length == LEN_WIDTH'(1)) ? S_DRAIN : S_RUN;
                  end else begin
                     r_result <= '0;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               r_ram_a_addr <= r_ram_a_addr + 1'b1;
               r_ram_b_addr <= r_ram_b_addr + 1'b1;
               r_cnt        <= w_cnt_next;
               r_vld_pipe   <= {r_vld_pipe[0], 1'b1};
               if (w_cnt_next == r_len) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_last_pair) begin
                  r_result <= w_acc_sum;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ram_a_addr = r_ram_a_addr;
   assign o_ram_b_addr = r_ram_b_addr;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_result     = r_result;

endmodule
